// File: rtl/idli_sqi_ctrl.sv
// -----------------------------------------------------------------------------
// idli_sqi_ctrl
//
// Burst controller for NUM_MEM SQI (quad-SPI) memories that share one chip
// select and one SCK enable. Memory m uses SIO bits [4m+3:4m]. Each burst
// drives a 2-cycle opcode, an ADDR_NIBBLES-cycle address, an optional read
// dummy phase, and then data until i_end. A single deselect cycle follows.
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_req_vld/o_req_rdy     burst request handshake (i_req_wr, i_req_addr)
//   i_wr_data/i_wr_vld/o_wr_rdy  write beat handshake
//   i_end                   ends the burst after the current data cycle
//   o_rd_data/o_rd_vld      read beats (no backpressure)
//   o_sqi_cs_n, o_sqi_sck_en, o_sqi_oe, o_sqi_sio, i_sqi_sio  SQI pins
//   dbg_state               current FSM state, for observation only
//
// Handshakes: a request transfers on a rising edge where i_req_vld and
// o_req_rdy are both high; a write beat transfers on a rising edge where
// i_wr_vld and o_wr_rdy are both high. o_rd_vld is a one-cycle strobe.
//
// All outputs are registered, so a write beat taken on an edge is driven on
// SIO (with sck_en=1) during the following cycle. The beat taken together
// with i_end therefore needs one trailing DATA cycle (o_wr_rdy low) before
// the memories are deselected.
// -----------------------------------------------------------------------------
module idli_sqi_ctrl #(
    parameter int         NUM_MEM      = 2,
    parameter int         ADDR_W       = 16,
    parameter int         ADDR_NIBBLES = 6,
    parameter int         DUMMY_CYCLES = 2,
    parameter logic [7:0] CMD_RD       = 8'h03,
    parameter logic [7:0] CMD_WR       = 8'h02
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req_vld,
    output logic                 o_req_rdy,
    input  logic                 i_req_wr,
    input  logic [ADDR_W-1:0]    i_req_addr,
    input  logic [4*NUM_MEM-1:0] i_wr_data,
    input  logic                 i_wr_vld,
    output logic                 o_wr_rdy,
    input  logic                 i_end,
    output logic [4*NUM_MEM-1:0] o_rd_data,
    output logic                 o_rd_vld,
    output logic                 o_sqi_cs_n,
    output logic                 o_sqi_sck_en,
    output logic                 o_sqi_oe,
    output logic [4*NUM_MEM-1:0] o_sqi_sio,
    input  logic [4*NUM_MEM-1:0] i_sqi_sio,
    output logic [2:0]           dbg_state
);

    localparam int DW      = 4 * NUM_MEM;
    localparam int AW      = 4 * ADDR_NIBBLES;
    localparam int MAX_A   = (ADDR_NIBBLES > 2) ? ADDR_NIBBLES : 2;
    localparam int MAX_CNT = (DUMMY_CYCLES > MAX_A) ? DUMMY_CYCLES : MAX_A;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        ADDR  = 3'd2,
        DUMMY = 3'd3,
        DATA  = 3'd4,
        DESEL = 3'd5
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             wr_q;
    logic             last_q;   // final write beat is on SIO this cycle
    logic [AW-1:0]    addr_sr;  // address, shifted out MSB nibble first
    logic [7:0]       op_in;
    logic [7:0]       op_q;

    assign op_in     = i_req_wr ? CMD_WR : CMD_RD;
    assign op_q      = wr_q ? CMD_WR : CMD_RD;
    assign dbg_state = state;

    // Same nibble on every memory (opcode and address phases).
    function automatic logic [DW-1:0] rep(input logic [3:0] nib);
        return {NUM_MEM{nib}};
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            wr_q         <= 1'b0;
            last_q       <= 1'b0;
            addr_sr      <= '0;
            o_req_rdy    <= 1'b1;
            o_wr_rdy     <= 1'b0;
            o_rd_data    <= '0;
            o_rd_vld     <= 1'b0;
            o_sqi_cs_n   <= 1'b1;
            o_sqi_sck_en <= 1'b0;
            o_sqi_oe     <= 1'b0;
            o_sqi_sio    <= '0;
        end else begin
            o_rd_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req_vld) begin
                        state        <= CMD;
                        cnt          <= '0;
                        wr_q         <= i_req_wr;
                        addr_sr      <= AW'(i_req_addr);
                        o_req_rdy    <= 1'b0;
                        o_sqi_cs_n   <= 1'b0;
                        o_sqi_oe     <= 1'b1;
                        o_sqi_sck_en <= 1'b1;
                        o_sqi_sio    <= rep(op_in[7:4]);
                    end
                end

                CMD: begin
                    if (cnt == '0) begin
                        cnt       <= cnt + 1'b1;
                        o_sqi_sio <= rep(op_q[3:0]);
                    end else begin
                        state     <= ADDR;
                        cnt       <= '0;
                        o_sqi_sio <= rep(addr_sr[AW-1 -: 4]);
                        addr_sr   <= addr_sr << 4;
                    end
                end

                ADDR: begin
                    if (cnt != CNT_W'(ADDR_NIBBLES - 1)) begin
                        cnt       <= cnt + 1'b1;
                        o_sqi_sio <= rep(addr_sr[AW-1 -: 4]);
                        addr_sr   <= addr_sr << 4;
                    end else begin
                        cnt <= '0;
                        if (wr_q) begin
                            // Keep driving; SCK stays off until the first beat.
                            state        <= DATA;
                            o_sqi_sck_en <= 1'b0;
                            o_wr_rdy     <= 1'b1;
                        end else begin
                            state        <= (DUMMY_CYCLES == 0) ? DATA : DUMMY;
                            o_sqi_oe     <= 1'b0;
                            o_sqi_sio    <= '0;
                            o_sqi_sck_en <= 1'b1;
                        end
                    end
                end

                DUMMY: begin
                    if (cnt == CNT_W'(DUMMY_CYCLES - 1)) begin
                        state <= DATA;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (!wr_q) begin
                        o_rd_data <= i_sqi_sio;
                        o_rd_vld  <= 1'b1;
                        if (i_end) begin
                            state        <= DESEL;
                            o_sqi_cs_n   <= 1'b1;
                            o_sqi_sck_en <= 1'b0;
                            o_sqi_oe     <= 1'b0;
                        end
                    end else if (last_q) begin
                        state        <= DESEL;
                        last_q       <= 1'b0;
                        o_sqi_cs_n   <= 1'b1;
                        o_sqi_sck_en <= 1'b0;
                        o_sqi_oe     <= 1'b0;
                        o_sqi_sio    <= '0;
                    end else if (i_wr_vld) begin
                        o_sqi_sio    <= i_wr_data;
                        o_sqi_sck_en <= 1'b1;
                        if (i_end) begin
                            last_q   <= 1'b1;
                            o_wr_rdy <= 1'b0;
                        end
                    end else begin
                        // Stall: SCK gated, chip stays selected.
                        o_sqi_sck_en <= 1'b0;
                        if (i_end) begin
                            state      <= DESEL;
                            o_wr_rdy   <= 1'b0;
                            o_sqi_cs_n <= 1'b1;
                            o_sqi_oe   <= 1'b0;
                            o_sqi_sio  <= '0;
                        end
                    end
                end

                DESEL: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    o_req_rdy <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idli_sqi_ctrl.sv
// -----------------------------------------------------------------------------
// tb_idli_sqi_ctrl
//
// Bench for idli_sqi_ctrl. A bus monitor at the falling edge models the SQI
// memories: every clocked cycle with oe=1 must match the next word expected
// for the burst (opcode, address nibbles, write beats), and every clocked
// cycle with oe=0 beyond the dummy count is a read beat whose data is chosen
// at random and queued for the o_rd_data check. A second instance with four
// memories runs a fixed read sequence.
// -----------------------------------------------------------------------------
module tb_idli_sqi_ctrl;

    localparam int NM  = 2;
    localparam int W   = 4 * NM;
    localparam int AN  = 6;
    localparam int DC  = 2;
    localparam int LIM = 200;

    // ------------------------------------------------------------ clock/reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ------------------------------------------------------------ main DUT
    logic          req_vld = 1'b0;
    logic          req_rdy;
    logic          req_wr = 1'b0;
    logic [15:0]   req_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic          wr_vld = 1'b0;
    logic          wr_rdy;
    logic          end_burst = 1'b0;
    logic [W-1:0]  rd_data;
    logic          rd_vld;
    logic          sqi_cs_n;
    logic          sqi_sck_en;
    logic          sqi_oe;
    logic [W-1:0]  sqi_sio;
    logic [W-1:0]  sqi_in = '0;
    logic [2:0]    dbg_state;

    idli_sqi_ctrl u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_vld(req_vld), .o_req_rdy(req_rdy), .i_req_wr(req_wr),
        .i_req_addr(req_addr), .i_wr_data(wr_data), .i_wr_vld(wr_vld),
        .o_wr_rdy(wr_rdy), .i_end(end_burst), .o_rd_data(rd_data),
        .o_rd_vld(rd_vld), .o_sqi_cs_n(sqi_cs_n), .o_sqi_sck_en(sqi_sck_en),
        .o_sqi_oe(sqi_oe), .o_sqi_sio(sqi_sio), .i_sqi_sio(sqi_in),
        .dbg_state(dbg_state)
    );

    // ------------------------------------------------------------ 4-memory DUT
    logic          q4_req_vld = 1'b0;
    logic          q4_req_rdy;
    logic [15:0]   q4_req_addr = '0;
    logic          q4_wr_rdy;
    logic          q4_end = 1'b0;
    logic [15:0]   q4_rd_data;
    logic          q4_rd_vld;
    logic          q4_cs_n;
    logic          q4_sck_en;
    logic          q4_oe;
    logic [15:0]   q4_sio;
    logic [15:0]   q4_in = '0;
    logic [2:0]    q4_state;

    idli_sqi_ctrl #(.NUM_MEM(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst),
        .i_req_vld(q4_req_vld), .o_req_rdy(q4_req_rdy), .i_req_wr(1'b0),
        .i_req_addr(q4_req_addr), .i_wr_data(16'h0), .i_wr_vld(1'b0),
        .o_wr_rdy(q4_wr_rdy), .i_end(q4_end), .o_rd_data(q4_rd_data),
        .o_rd_vld(q4_rd_vld), .o_sqi_cs_n(q4_cs_n), .o_sqi_sck_en(q4_sck_en),
        .o_sqi_oe(q4_oe), .o_sqi_sio(q4_sio), .i_sqi_sio(q4_in),
        .dbg_state(q4_state)
    );

    // ------------------------------------------------------------ scoreboard
    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];     // expected SIO words on clocked oe=1 cycles
    logic [W-1:0] exp_rd[$];    // expected read beats
    int           exp_oe0[$];   // expected clocked oe=0 cycles per burst
    int           exp_nrd[$];   // expected rd_vld pulses per burst

    bit           in_burst  = 1'b0;
    bit           desel_chk = 1'b0;
    int           oe0_cnt   = 0;
    int           nrd_cnt   = 0;
    bit           use_fixed = 1'b0;
    logic [W-1:0] fixed_val = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory-side model and bus monitor.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_rd.delete();
            exp_oe0.delete();
            exp_nrd.delete();
            in_burst  = 1'b0;
            desel_chk = 1'b0;
            sqi_in    = '0;
        end else begin
            if (desel_chk) begin
                check("idle_after_desel_rdy", 64'(req_rdy), 64'(1));
                desel_chk = 1'b0;
            end
            if (rd_vld) begin
                nrd_cnt++;
                check("rd_vld_expected", 64'(exp_rd.size() != 0), 64'(1));
                if (exp_rd.size() != 0) check("rd_data", 64'(rd_data), 64'(exp_rd.pop_front()));
            end
            sqi_in = W'($urandom);
            if (!sqi_cs_n) begin
                check("rdy_low_in_burst", 64'(req_rdy), 64'(0));
                if (!in_burst) begin
                    in_burst = 1'b1;
                    oe0_cnt  = 0;
                    nrd_cnt  = 0;
                end
                if (sqi_sck_en && sqi_oe) begin
                    check("sio_expected", 64'(exp_q.size() != 0), 64'(1));
                    if (exp_q.size() != 0) check("sio", 64'(sqi_sio), 64'(exp_q.pop_front()));
                end
                if (sqi_sck_en && !sqi_oe) begin
                    oe0_cnt++;
                    if (oe0_cnt > DC) begin
                        if (use_fixed) sqi_in = fixed_val;
                        exp_rd.push_back(sqi_in);
                    end
                end
            end else begin
                check("desel_oe", 64'({sqi_oe, sqi_sck_en}), 64'(0));
                if (in_burst) begin
                    in_burst = 1'b0;
                    check("desel_rdy", 64'(req_rdy), 64'(0));
                    check("burst_expected", 64'(exp_oe0.size() != 0), 64'(1));
                    if (exp_oe0.size() != 0) begin
                        check("burst_oe0_cycles", 64'(oe0_cnt), 64'(exp_oe0.pop_front()));
                        check("burst_rd_beats", 64'(nrd_cnt), 64'(exp_nrd.pop_front()));
                    end
                    check("burst_bus_left", 64'(exp_q.size()), 64'(0));
                    desel_chk = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------ drivers
    task automatic push_hdr(input bit wr, input logic [15:0] a);
        logic [7:0]    op;
        logic [4*AN-1:0] a_ext;
        op    = wr ? 8'h02 : 8'h03;
        a_ext = (4*AN)'(a);
        exp_q.push_back({NM{op[7:4]}});
        exp_q.push_back({NM{op[3:0]}});
        for (int i = AN - 1; i >= 0; i--) exp_q.push_back({NM{a_ext[4*i +: 4]}});
    endtask

    // Returns at the falling edge of the first CMD cycle.
    task automatic issue(input bit wr, input logic [15:0] a, input int nb, input bit hold);
        int t = 0;
        @(negedge clk);
        req_vld  = 1'b1;
        req_wr   = wr;
        req_addr = a;
        while (!req_rdy && t < LIM) begin
            @(negedge clk);
            t++;
        end
        check("req_accept_wait", 64'(t >= LIM), 64'(0));
        push_hdr(wr, a);
        exp_oe0.push_back(wr ? 0 : DC + nb);
        exp_nrd.push_back(wr ? 0 : nb);
        @(negedge clk);
        if (!hold) begin
            req_vld  = 1'b0;
            req_wr   = 1'($urandom);
            req_addr = 16'($urandom);
        end
    endtask

    // Returns at the falling edge of the deselect cycle.
    task automatic do_read(input logic [15:0] a, input int nb, input bit hold);
        int k = 0;
        int t = 0;
        issue(1'b0, a, nb, hold);
        while (t < LIM) begin
            if (!sqi_cs_n && sqi_sck_en && !sqi_oe) k++;
            if (k == DC + nb) begin
                end_burst = 1'b1;
                @(negedge clk);
                end_burst = 1'b0;
                break;
            end
            // i_end before the data phase must be ignored.
            end_burst = (k <= DC) ? 1'($urandom) : 1'b0;
            @(negedge clk);
            t++;
        end
        check("rd_end_wait", 64'(t >= LIM), 64'(0));
        t = 0;
        while (!sqi_cs_n && t < LIM) begin
            @(negedge clk);
            t++;
        end
        check("rd_desel_wait", 64'(t >= LIM), 64'(0));
    endtask

    task automatic do_write(input logic [15:0] a, input int nb, input bit end_nobeat);
        int sent = 0;
        int t = 0;
        issue(1'b1, a, nb, 1'b0);
        while (t < LIM) begin
            if (wr_rdy) begin
                if (sent == nb) begin
                    wr_vld    = 1'b0;
                    end_burst = 1'b1;
                    @(negedge clk);
                    end_burst = 1'b0;
                    break;
                end
                if ($urandom_range(0, 3) != 0) begin
                    wr_vld  = 1'b1;
                    wr_data = W'($urandom);
                    exp_q.push_back(wr_data);
                    sent++;
                    end_burst = (sent == nb) && !end_nobeat;
                end else begin
                    wr_vld    = 1'b0;
                    wr_data   = W'($urandom);
                    end_burst = 1'b0;
                end
                @(negedge clk);
                t++;
                if (sent == nb && !end_nobeat) begin
                    wr_vld    = 1'b0;
                    end_burst = 1'b0;
                    break;
                end
            end else begin
                // Beats and i_end offered while not ready must be ignored.
                wr_vld    = 1'($urandom);
                wr_data   = W'($urandom);
                end_burst = 1'($urandom);
                @(negedge clk);
                t++;
            end
        end
        wr_vld    = 1'b0;
        end_burst = 1'b0;
        check("wr_end_wait", 64'(t >= LIM), 64'(0));
        t = 0;
        while (!sqi_cs_n && t < LIM) begin
            @(negedge clk);
            t++;
        end
        check("wr_desel_wait", 64'(t >= LIM), 64'(0));
    endtask

    // ------------------------------------------------------------ sequence
    logic [3:0]  tbl [8];
    logic [15:0] q4_val;

    initial begin
        tbl = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4};

        repeat (3) @(negedge clk);
        check("rst_cs_n",    64'(sqi_cs_n),   64'(1));
        check("rst_oe",      64'(sqi_oe),     64'(0));
        check("rst_sck_en",  64'(sqi_sck_en), 64'(0));
        check("rst_req_rdy", 64'(req_rdy),    64'(1));
        check("rst_rd_vld",  64'(rd_vld),     64'(0));
        check("rst_wr_rdy",  64'(wr_rdy),     64'(0));
        check("rst_sio",     64'(sqi_sio),    64'(0));
        rst = 1'b0;

        // Read of 0x1234, memories return lo=A hi=5, single beat.
        use_fixed = 1'b1;
        fixed_val = 8'h5A;
        do_read(16'h1234, 1, 1'b0);
        use_fixed = 1'b0;

        do_write(16'h0000, 3, 1'b0);
        do_write(16'h00FF, 2, 1'b1);
        do_read(16'hFFFF, 4, 1'b0);

        for (int it = 0; it < 30; it++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 1) == 1)
                do_read(16'($urandom), $urandom_range(1, 6), 1'b0);
            else
                do_write(16'($urandom), $urandom_range(1, 5), $urandom_range(0, 3) == 0);
        end

        // Request held through a burst: next one only after deselect.
        do_read(16'hA5A5, 2, 1'b1);
        do_read(16'h0F0F, 1, 1'b0);

        // Reset in the third address cycle.
        issue(1'b0, 16'hBEEF, 1, 1'b0);
        repeat (4) @(negedge clk);
        check("pre_rst_addr_oe", 64'({sqi_cs_n, sqi_oe}), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("async_rst_cs_n",  64'(sqi_cs_n),   64'(1));
        check("async_rst_oe",    64'(sqi_oe),     64'(0));
        check("async_rst_sck",   64'(sqi_sck_en), 64'(0));
        check("async_rst_rdy",   64'(req_rdy),    64'(1));
        check("async_rst_sio",   64'(sqi_sio),    64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_read(16'h00C3, 2, 1'b0);

        // Four memories: 16-bit SIO words.
        @(negedge clk);
        q4_req_vld  = 1'b1;
        q4_req_addr = 16'h1234;
        check("q4_req_rdy", 64'(q4_req_rdy), 64'(1));
        @(negedge clk);
        q4_req_vld = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("q4_hdr_ctl", 64'({q4_cs_n, q4_sck_en, q4_oe}), 64'(3'b011));
            check("q4_hdr_sio", 64'(q4_sio), 64'({4{tbl[i]}}));
            @(negedge clk);
        end
        for (int i = 0; i < DC; i++) begin
            check("q4_dummy_ctl", 64'({q4_cs_n, q4_sck_en, q4_oe}), 64'(3'b010));
            @(negedge clk);
        end
        check("q4_data_ctl", 64'({q4_cs_n, q4_sck_en, q4_oe}), 64'(3'b010));
        q4_val = 16'($urandom);
        q4_in  = q4_val;
        q4_end = 1'b1;
        @(negedge clk);
        q4_end = 1'b0;
        check("q4_rd_vld",  64'(q4_rd_vld),  64'(1));
        check("q4_rd_data", 64'(q4_rd_data), 64'(q4_val));
        check("q4_desel",   64'({q4_cs_n, q4_req_rdy}), 64'(2'b10));
        @(negedge clk);
        check("q4_idle",    64'({q4_cs_n, q4_req_rdy, q4_rd_vld}), 64'(3'b110));

        repeat (3) @(negedge clk);
        check("final_queues_empty", 64'(exp_q.size() + exp_rd.size() + exp_oe0.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
